// File: rtl/gpu_ctrl_responder.sv
// Device-side GPU control responder: latches kernel config from host commands,
// launches kernels to the dispatcher and guards each run with a watchdog.
module gpu_ctrl_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op_code,
    input  logic [ADDR_WIDTH-1:0] cfg_data,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] thread_count,
    output logic                  kernel_start,
    input  logic                  kernel_done,
    input  logic                  err_clr,
    output logic                  err_overrun,
    output logic                  err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        LAUNCH,
        RUN,
        DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [WD_W-1:0]         watchdog, watchdog_nxt;
    logic [ADDR_WIDTH-1:0]   base_nxt, threads_nxt;
    logic                    busy_nxt, kstart_nxt;
    logic                    overrun_nxt, timeout_nxt;
    logic                    timeout_set, overrun_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            watchdog     <= '0;
            base_addr    <= '0;
            thread_count <= '0;
            busy         <= 1'b0;
            kernel_start <= 1'b0;
            err_overrun  <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_nxt;
            watchdog     <= watchdog_nxt;
            base_addr    <= base_nxt;
            thread_count <= threads_nxt;
            busy         <= busy_nxt;
            kernel_start <= kstart_nxt;
            err_overrun  <= overrun_nxt;
            err_timeout  <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        watchdog_nxt = watchdog;
        base_nxt     = base_addr;
        threads_nxt  = thread_count;
        timeout_set  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    case (op_code)
                        2'b01: begin
                            base_nxt  = cfg_data;
                            state_nxt = CFG;
                        end
                        2'b10: begin
                            threads_nxt = cfg_data;
                            state_nxt   = CFG;
                        end
                        // A launch with no threads retires like a config command.
                        2'b11:   state_nxt = (thread_count != '0) ? LAUNCH : CFG;
                        default: state_nxt = CFG;
                    endcase
                end
            end
            CFG:    state_nxt = IDLE;
            LAUNCH: begin
                watchdog_nxt = '0;
                state_nxt    = RUN;
            end
            RUN: begin
                if (kernel_done) begin
                    state_nxt = DONE;
                end else if (watchdog == WD_LAST) begin
                    timeout_set = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    watchdog_nxt = watchdog + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // busy mirrors state, so it doubles as the "already busy" indicator here.
        overrun_set = start && busy;
        busy_nxt    = (state_nxt != IDLE);
        kstart_nxt  = (state_nxt == LAUNCH);
        overrun_nxt = overrun_set | (err_overrun & ~err_clr);
        timeout_nxt = timeout_set | (err_timeout & ~err_clr);
    end

endmodule

// File: tb/tb_gpu_ctrl_responder.sv
// Bench for gpu_ctrl_responder: vector table, hand-written corner sequences,
// and randomized traffic against a time-based reference model.
module tb_gpu_ctrl_responder;

    localparam int AW  = 16;
    localparam int TMO = 16;
    localparam int BIG = 1 << 30;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    op_code;
    logic [AW-1:0] cfg_data;
    logic          busy;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] thread_count;
    logic          kernel_start;
    logic          kernel_done;
    logic          err_clr;
    logic          err_overrun;
    logic          err_timeout;

    int tests  = 0;
    int failed = 0;

    gpu_ctrl_responder #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code), .cfg_data(cfg_data),
        .busy(busy), .base_addr(base_addr), .thread_count(thread_count),
        .kernel_start(kernel_start), .kernel_done(kernel_done), .err_clr(err_clr),
        .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          s;
        logic [1:0]    op;
        logic [AW-1:0] d;
        logic          dn;
        logic          c;
        logic          busy;
        logic [AW-1:0] base;
        logic [AW-1:0] thr;
        logic          ks;
        logic          ovr;
        logic          tmo;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(logic s, logic [1:0] op, logic [AW-1:0] d, logic dn, logic c,
                                logic b, logic [AW-1:0] ba, logic [AW-1:0] th,
                                logic ks, logic ovr, logic tmo);
        vec_t v;
        v.s = s; v.op = op; v.d = d; v.dn = dn; v.c = c;
        v.busy = b; v.base = ba; v.thr = th; v.ks = ks; v.ovr = ovr; v.tmo = tmo;
        return v;
    endfunction

    function automatic logic [35:0] pack(logic b, logic [AW-1:0] ba, logic [AW-1:0] th,
                                         logic ks, logic ovr, logic tmo);
        return {b, ba, th, ks, ovr, tmo};
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] outs();
        return pack(busy, base_addr, thread_count, kernel_start, err_overrun, err_timeout);
    endfunction

    task automatic step(input logic s, input logic [1:0] op, input logic [AW-1:0] d,
                        input logic dn, input logic c);
        start = s; op_code = op; cfg_data = d; kernel_done = dn; err_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 2'd0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: tracks when the current command retires, in edge counts.
    int            cyc, free_at, launch_at;
    bit            running;
    logic [AW-1:0] m_base, m_thr;
    logic          m_busy, m_ks, m_ovr, m_tmo;

    function automatic void model_reset();
        cyc = -1; free_at = 0; launch_at = 0; running = 0;
        m_base = '0; m_thr = '0; m_busy = 0; m_ks = 0; m_ovr = 0; m_tmo = 0;
    endfunction

    function automatic void model_step(logic s, logic [1:0] op, logic [AW-1:0] d,
                                       logic dn, logic c);
        logic set_ovr, set_tmo;
        cyc++;
        set_ovr = s && m_busy;
        set_tmo = 0;
        if (running) begin
            if (cyc >= launch_at + 2 && dn) begin
                running = 0; free_at = cyc + 1;
            end else if (cyc == launch_at + 1 + TMO) begin
                running = 0; free_at = cyc + 1; set_tmo = 1;
            end
        end
        if (s && !m_busy) begin
            if (op == 2'd1) m_base = d;
            if (op == 2'd2) m_thr = d;
            if (op == 2'd3 && m_thr != 0) begin
                running = 1; launch_at = cyc; free_at = BIG;
            end else begin
                free_at = cyc + 1;
            end
        end
        m_ks   = running && (cyc == launch_at);
        m_ovr  = set_ovr ? 1'b1 : (c ? 1'b0 : m_ovr);
        m_tmo  = set_tmo ? 1'b1 : (c ? 1'b0 : m_tmo);
        m_busy = cyc < free_at;
    endfunction

    initial begin
        rst_n = 1'b0; start = 0; op_code = 0; cfg_data = 0; kernel_done = 0; err_clr = 0;

        vecs[0]  = mk(1, 2'd1, 16'h40, 0, 0,  1, 16'h40, 16'h0, 0, 0, 0);
        vecs[1]  = mk(0, 2'd0, 16'h0,  0, 0,  0, 16'h40, 16'h0, 0, 0, 0);
        vecs[2]  = mk(1, 2'd2, 16'h8,  0, 0,  1, 16'h40, 16'h8, 0, 0, 0);
        vecs[3]  = mk(0, 2'd0, 16'h0,  0, 0,  0, 16'h40, 16'h8, 0, 0, 0);
        vecs[4]  = mk(1, 2'd3, 16'h0,  0, 0,  1, 16'h40, 16'h8, 1, 0, 0);
        vecs[5]  = mk(0, 2'd0, 16'h0,  0, 0,  1, 16'h40, 16'h8, 0, 0, 0);
        vecs[6]  = mk(0, 2'd0, 16'h0,  0, 0,  1, 16'h40, 16'h8, 0, 0, 0);
        vecs[7]  = mk(0, 2'd0, 16'h0,  0, 0,  1, 16'h40, 16'h8, 0, 0, 0);
        vecs[8]  = mk(0, 2'd0, 16'h0,  0, 0,  1, 16'h40, 16'h8, 0, 0, 0);
        vecs[9]  = mk(0, 2'd0, 16'h0,  1, 0,  1, 16'h40, 16'h8, 0, 0, 0);
        vecs[10] = mk(0, 2'd0, 16'h0,  0, 0,  0, 16'h40, 16'h8, 0, 0, 0);
        vecs[11] = mk(1, 2'd3, 16'h0,  0, 0,  1, 16'h40, 16'h8, 1, 0, 0);
        vecs[12] = mk(0, 2'd0, 16'h0,  1, 0,  1, 16'h40, 16'h8, 0, 0, 0);
        vecs[13] = mk(1, 2'd1, 16'h11, 0, 0,  1, 16'h40, 16'h8, 0, 1, 0);
        vecs[14] = mk(0, 2'd0, 16'h0,  1, 0,  1, 16'h40, 16'h8, 0, 1, 0);
        vecs[15] = mk(0, 2'd0, 16'h0,  0, 0,  0, 16'h40, 16'h8, 0, 1, 0);
        vecs[16] = mk(0, 2'd0, 16'h0,  1, 0,  0, 16'h40, 16'h8, 0, 1, 0);
        vecs[17] = mk(0, 2'd0, 16'h0,  0, 1,  0, 16'h40, 16'h8, 0, 0, 0);
        vecs[18] = mk(1, 2'd2, 16'h0,  0, 0,  1, 16'h40, 16'h0, 0, 0, 0);
        vecs[19] = mk(0, 2'd0, 16'h0,  0, 0,  0, 16'h40, 16'h0, 0, 0, 0);
        vecs[20] = mk(1, 2'd3, 16'h0,  0, 0,  1, 16'h40, 16'h0, 0, 0, 0);
        vecs[21] = mk(0, 2'd0, 16'h0,  0, 0,  0, 16'h40, 16'h0, 0, 0, 0);
        vecs[22] = mk(1, 2'd2, 16'h3,  0, 0,  1, 16'h40, 16'h3, 0, 0, 0);
        vecs[23] = mk(1, 2'd0, 16'h0,  0, 1,  0, 16'h40, 16'h3, 0, 1, 0);
        vecs[24] = mk(0, 2'd0, 16'h0,  0, 1,  0, 16'h40, 16'h3, 0, 0, 0);

        // Reset values, both during reset and right after release
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", outs(), '0);
        rst_n = 1'b1;
        step(1'b0, 2'd0, '0, 1'b0, 1'b0);
        check("reset_release", outs(), '0);

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].s, vecs[i].op, vecs[i].d, vecs[i].dn, vecs[i].c);
            check($sformatf("vec%0d", i), outs(),
                  pack(vecs[i].busy, vecs[i].base, vecs[i].thr, vecs[i].ks, vecs[i].ovr, vecs[i].tmo));
        end

        // Watchdog expiry with thread_count=3
        step(1'b1, 2'd3, '0, 1'b0, 1'b0);
        check("wd_kstart", {35'd0, kernel_start}, 36'd1);
        for (int k = 1; k <= 18; k++) begin
            step(1'b0, 2'd0, '0, 1'b0, 1'b0);
            if (k == 16) check("wd_before", {34'd0, busy, err_timeout}, 36'b10);
            if (k == 17) check("wd_expire", {34'd0, busy, err_timeout}, 36'b11);
            if (k == 18) check("wd_idle",   {34'd0, busy, err_timeout}, 36'b01);
        end
        step(1'b0, 2'd0, '0, 1'b0, 1'b1);
        check("wd_clr", {35'd0, err_timeout}, 36'd0);

        // kernel_done on the expiry edge wins over the watchdog
        step(1'b1, 2'd3, '0, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) step(1'b0, 2'd0, '0, 1'b0, 1'b0);
        step(1'b0, 2'd0, '0, 1'b1, 1'b0);
        check("race_done", {34'd0, busy, err_timeout}, 36'b10);
        step(1'b0, 2'd0, '0, 1'b0, 1'b0);
        check("race_idle", {34'd0, busy, err_timeout}, 36'b00);

        // Asynchronous reset in the middle of a run
        step(1'b1, 2'd3, '0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 2'd0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", outs(), '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 2'd2, 16'h5, 1'b0, 1'b0);
        step(1'b0, 2'd0, '0, 1'b0, 1'b0);
        step(1'b1, 2'd3, '0, 1'b0, 1'b0);
        check("relaunch", outs(), pack(1, 16'h0, 16'h5, 1, 0, 0));

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            logic          s, dn, c;
            logic [1:0]    op;
            logic [AW-1:0] d;
            s  = ($urandom_range(0, 3) == 0);
            op = 2'($urandom_range(0, 3));
            d  = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom);
            dn = ($urandom_range(0, 7) == 0);
            c  = ($urandom_range(0, 15) == 0);
            step(s, op, d, dn, c);
            model_step(s, op, d, dn, c);
            check($sformatf("rand%0d", n), outs(),
                  pack(m_busy, m_base, m_thr, m_ks, m_ovr, m_tmo));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
